dma_job_arbiter: RTL
====================

DMA_JOB_ARBITER -- requirements
Module: dma_job_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 64, virtual byte address width.
REQ-002 SHALL have parameter SIZE_WIDTH, default 43, transfer size width in cache lines.
REQ-003 SHALL have parameter DATA_WIDTH, default 512, cache-line width.
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 req  in  2  per-client job request level, held until that client's done.
REQ-007 rd_addr  in  2xADDR_WIDTH  per-client source address.
REQ-008 wr_addr  in  2xADDR_WIDTH  per-client destination address.
REQ-009 size  in  2xSIZE_WIDTH  per-client job length in cache lines.
REQ-010 grant  out  2  one-hot (or zero) owner of DMA.
REQ-011 done  out  2  one-cycle per-client job-complete pulse.
REQ-012 c_rd_en  in  2  per-client read enable.
REQ-013 c_wr_en  in  2  per-client write enable.
REQ-014 c_wr_data  in  2xDATA_WIDTH  per-client write data.
REQ-015 c_empty  out  2  per-client view of DMA empty.
REQ-016 c_full  out  2  per-client view of DMA full.
REQ-017 dma_rd_addr / dma_wr_addr  out  ADDR_WIDTH each  latched job addresses.
REQ-018 dma_rd_size / dma_wr_size  out  SIZE_WIDTH each  latched job size.
REQ-019 dma_rd_go / dma_wr_go  out  1 each  start pulses.
REQ-020 dma_rd_en / dma_wr_en  out  1 each  muxed enables.
REQ-021 dma_wr_data  out  DATA_WIDTH  muxed write data; dma_rd_data is routed to clients outside this block.
REQ-022 dma_empty, dma_full, dma_rd_done, dma_wr_done  in  1 each  DMA status.

Function
REQ-023 SHALL implement the FSM IDLE -> LAUNCH -> SETTLE -> BUSY -> FINISH -> IDLE.
REQ-024 IDLE: if any req, SHALL pick the winner round-robin (priority to the client not served last; client 0 first after reset), then latch its rd_addr/wr_addr/size, set grant, and go to LAUNCH on the next cycle.
REQ-025 Winner size==0 SHALL go IDLE -> FINISH directly, with grant set for that one FINISH cycle, no go pulses, and no DMA traffic.
REQ-026 LAUNCH SHALL assert dma_rd_go and dma_wr_go together for exactly one cycle.
REQ-027 SETTLE SHALL last one cycle and ignore the done inputs, masking stale done from the prior job.
REQ-028 BUSY SHALL stay until dma_rd_done && dma_wr_done are both high, then go to FINISH.
REQ-029 FINISH SHALL pulse done[owner] for one cycle, flip the round-robin pointer, clear grant, and return to IDLE.
REQ-030 Minimum non-zero job overhead: done SHALL pulse no earlier than 3 cycles after grant rises.
REQ-031 dma_rd_en/dma_wr_en SHALL equal c_rd_en/c_wr_en of the owner, ANDed with ~dma_empty/~dma_full, only in SETTLE/BUSY; otherwise 0.
REQ-032 Non-owner enables SHALL be ignored; non-owner c_empty=1 and c_full=1; owner sees dma_empty/dma_full directly, combinationally.
REQ-033 Latched address/size outputs SHALL stay stable from LAUNCH through FINISH regardless of client inputs.
REQ-034 Requests are not pre-empted; a req drop mid-job SHALL NOT abort the job.
REQ-035 Simultaneous req in IDLE SHALL be resolved by the pointer only; done and a new grant never occur in the same cycle.

Reset
REQ-036 On rst: state IDLE, grant=0, done=0, go pulses=0, enables=0, c_empty=2'b11, c_full=2'b11, latched addr/size=0, pointer=client 0.
REQ-037 rst mid-job SHALL abandon the job with no done pulse; the DMA is restarted by the next LAUNCH.

Structure
REQ-038 The FSM state enum and the default widths SHALL reside in shared package dma_arb_pkg.
REQ-039 Round-robin select SHALL be sub-module rr_arbiter2 (req[1:0], pointer -> one-hot winner).

Verification
REQ-040 req=01, size0=4, DMA model drains 4 lines -> grant=01, one rd_go/wr_go pulse, 4 dma_rd_en, done=01 once.
REQ-041 req=11 held, sizes 2 and 3 -> grants in order 01, 10, 01, 10; no overlap; done pulses alternate.
REQ-042 req=10, size1=0 -> done=10 on cycle 2 after req, no go pulses, zero DMA enables.
REQ-043 Owner holds c_rd_en with dma_empty=1 for 10 cycles, non-owner toggles c_wr_en -> dma_rd_en=0 and dma_wr_en=0 throughout.
REQ-044 dma_rd_done/wr_done left high from prior job, new job size=5 -> done not before 5 lines transferred.
REQ-045 rst asserted in BUSY -> all outputs at reset values same cycle, no done; next req=01 restarts with fresh go.

Source files
------------

// File: rtl/dma_arb_pkg.sv
// Shared definitions for the two-client DMA job arbiter: default widths and FSM state encoding.
package dma_arb_pkg;

  localparam int ADDR_WIDTH_DEF = 64;
  localparam int SIZE_WIDTH_DEF = 43;
  localparam int DATA_WIDTH_DEF = 512;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_SETTLE = 3'd2,
    ST_BUSY   = 3'd3,
    ST_FINISH = 3'd4
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin select: the client named by ptr has priority, the other wins only if it alone requests.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] winner
);

  // Priority select steered by the pointer
  always_comb begin
    winner = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0]) begin
        winner = 2'b01;
      end else if (req[1]) begin
        winner = 2'b10;
      end else begin
        winner = 2'b00;
      end
    end else begin
      if (req[1]) begin
        winner = 2'b10;
      end else if (req[0]) begin
        winner = 2'b01;
      end else begin
        winner = 2'b00;
      end
    end
  end

endmodule

// File: rtl/dma_job_arbiter.sv
// Shares one DMA engine between two clients: round-robin job grant, job parameter latching,
// launch/settle/busy sequencing and per-owner routing of the streaming enables and status.
module dma_job_arbiter
  import dma_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int SIZE_WIDTH = SIZE_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [1:0]                 req,
  input  logic [1:0][ADDR_WIDTH-1:0] rd_addr,
  input  logic [1:0][ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0][SIZE_WIDTH-1:0] size,
  output logic [1:0]                 grant,
  output logic [1:0]                 done,
  input  logic [1:0]                 c_rd_en,
  input  logic [1:0]                 c_wr_en,
  input  logic [1:0][DATA_WIDTH-1:0] c_wr_data,
  output logic [1:0]                 c_empty,
  output logic [1:0]                 c_full,
  output logic [ADDR_WIDTH-1:0]      dma_rd_addr,
  output logic [ADDR_WIDTH-1:0]      dma_wr_addr,
  output logic [SIZE_WIDTH-1:0]      dma_rd_size,
  output logic [SIZE_WIDTH-1:0]      dma_wr_size,
  output logic                       dma_rd_go,
  output logic                       dma_wr_go,
  output logic                       dma_rd_en,
  output logic                       dma_wr_en,
  output logic [DATA_WIDTH-1:0]      dma_wr_data,
  input  logic                       dma_empty,
  input  logic                       dma_full,
  input  logic                       dma_rd_done,
  input  logic                       dma_wr_done
);

  arb_state_e            state_r;
  logic [1:0]            grant_r;
  logic [1:0]            done_r;
  logic                  owner_r;
  logic                  ptr_r;
  logic                  go_r;
  logic [ADDR_WIDTH-1:0] rd_addr_r;
  logic [ADDR_WIDTH-1:0] wr_addr_r;
  logic [SIZE_WIDTH-1:0] size_r;
  logic [1:0]            winner_s;
  logic                  win_idx_s;
  logic                  xfer_s;

  rr_arbiter2 u_rr (
    .req    (req),
    .ptr    (ptr_r),
    .winner (winner_s)
  );

  assign win_idx_s   = winner_s[1];
  assign xfer_s      = (state_r == ST_SETTLE) || (state_r == ST_BUSY);
  assign grant       = grant_r;
  assign done        = done_r;
  assign dma_rd_addr = rd_addr_r;
  assign dma_wr_addr = wr_addr_r;
  assign dma_rd_size = size_r;
  assign dma_wr_size = size_r;
  assign dma_rd_go   = go_r;
  assign dma_wr_go   = go_r;

  // Job sequencer; SETTLE exists so done flags left over from the previous job are never seen
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      grant_r   <= 2'b00;
      done_r    <= 2'b00;
      owner_r   <= 1'b0;
      ptr_r     <= 1'b0;
      go_r      <= 1'b0;
      rd_addr_r <= {ADDR_WIDTH{1'b0}};
      wr_addr_r <= {ADDR_WIDTH{1'b0}};
      size_r    <= {SIZE_WIDTH{1'b0}};
    end else begin
      go_r   <= 1'b0;
      done_r <= 2'b00;
      case (state_r)
        ST_IDLE: begin
          if (winner_s != 2'b00) begin
            grant_r   <= winner_s;
            owner_r   <= win_idx_s;
            rd_addr_r <= rd_addr[win_idx_s];
            wr_addr_r <= wr_addr[win_idx_s];
            size_r    <= size[win_idx_s];
            if (size[win_idx_s] == {SIZE_WIDTH{1'b0}}) begin
              done_r  <= winner_s;
              state_r <= ST_FINISH;
            end else begin
              go_r    <= 1'b1;
              state_r <= ST_LAUNCH;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_LAUNCH: state_r <= ST_SETTLE;
        ST_SETTLE: state_r <= ST_BUSY;
        ST_BUSY: begin
          if (dma_rd_done && dma_wr_done) begin
            done_r  <= grant_r;
            state_r <= ST_FINISH;
          end else begin
            state_r <= ST_BUSY;
          end
        end
        ST_FINISH: begin
          grant_r <= 2'b00;
          ptr_r   <= ~owner_r;
          state_r <= ST_IDLE;
        end
        default: begin
          grant_r <= 2'b00;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Streaming path: only the owner's enables reach the DMA, and only while data may move
  always_comb begin
    dma_rd_en   = 1'b0;
    dma_wr_en   = 1'b0;
    dma_wr_data = {DATA_WIDTH{1'b0}};
    if (xfer_s) begin
      dma_rd_en   = c_rd_en[owner_r] & ~dma_empty;
      dma_wr_en   = c_wr_en[owner_r] & ~dma_full;
      dma_wr_data = c_wr_data[owner_r];
    end else begin
      dma_rd_en   = 1'b0;
      dma_wr_en   = 1'b0;
      dma_wr_data = {DATA_WIDTH{1'b0}};
    end
  end

  // Status fan-out: non-owners always see an empty, full DMA
  always_comb begin
    c_empty = 2'b11;
    c_full  = 2'b11;
    if (grant_r[0]) begin
      c_empty[0] = dma_empty;
      c_full[0]  = dma_full;
    end else begin
      c_empty[0] = 1'b1;
      c_full[0]  = 1'b1;
    end
    if (grant_r[1]) begin
      c_empty[1] = dma_empty;
      c_full[1]  = dma_full;
    end else begin
      c_empty[1] = 1'b1;
      c_full[1]  = 1'b1;
    end
  end

endmodule
